cpa_resolve_n40: RTL



---
 rtl/cpa_resolve_n40.sv | 111 +++++++++++
 1 files changed

// File: rtl/cpa_resolve_n40.sv
// Sequential carry-propagate resolver: folds a 40-bit carry-save pair (S0, S1, CIN)
// into a binary sum using one CHUNK-bit adder stepped from LSB to MSB chunk.
module cpa_resolve_n40 #(
   parameter int CHUNK = 10
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic [39:0] S0,
   input  logic [39:0] S1,
   input  logic        CIN,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic [39:0] SUM,
   output logic        OVF,
   output logic        OUT_VALID,
   input  logic        OUT_READY
);

   localparam int N  = 40 / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [39:0]       a_reg;
   logic [39:0]       b_reg;
   logic              hi_reg;
   logic              carry_reg;
   logic              ovf_reg;
   logic [KW-1:0]     k_reg;
   logic [CHUNK:0]    chunk_sum;
   logic              last_chunk;

   // A and B shift right each ADD cycle so the active chunk is always at the bottom.
   assign chunk_sum  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_reg};
   assign last_chunk = (k_reg == KW'(N - 1));

   assign IN_READY  = (state_reg == IDLE);
   assign OUT_VALID = (state_reg == DONE);
   assign OVF       = ovf_reg;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (IN_VALID)   state_next = ADD;
         ADD:     if (last_chunk) state_next = DONE;
         DONE:    if (OUT_READY)  state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         a_reg     <= '0;
         b_reg     <= '0;
         hi_reg    <= 1'b0;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         k_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (IN_VALID) begin
                  a_reg     <= S0;
                  b_reg     <= {S1[38:0], 1'b0};
                  hi_reg    <= S1[39];
                  carry_reg <= CIN;
                  k_reg     <= '0;
               end
            end
            ADD: begin
               a_reg     <= a_reg >> CHUNK;
               b_reg     <= b_reg >> CHUNK;
               carry_reg <= chunk_sum[CHUNK];
               k_reg     <= k_reg + 1'b1;
               // S1[39] carries weight 2^40, so it can only ever show up as overflow.
               if (last_chunk) begin
                  ovf_reg <= chunk_sum[CHUNK] | hi_reg;
               end
            end
            default: ;
         endcase
      end
   end

   // One result register per chunk; only the chunk selected by k is written.
   for (genvar gi = 0; gi < N; gi++) begin : g_chunk
      logic [CHUNK-1:0] chunk_reg;

      always_ff @(posedge CLK or negedge nRESET) begin
         if (!nRESET) begin
            chunk_reg <= '0;
         end else if (state_reg == ADD && k_reg == KW'(gi)) begin
            chunk_reg <= chunk_sum[CHUNK-1:0];
         end
      end

      assign SUM[gi*CHUNK +: CHUNK] = chunk_reg;
   end

endmodule
